// File: rtl/lif_spike_monitor.sv
// Timestamps rising edges of a LIF neuron's spike output and buffers {ts, state} in a
// first-word-fall-through FIFO drained over valid/ready. Optional spike-rate window: SPIKE_RATE_EN.
module lif_spike_monitor #(
    parameter int TS_W     = 8,
    parameter int DEPTH    = 4,
    parameter int WIN_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     spike,
    input  logic [7:0]               state,
    input  logic                     clear,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [7:0]               evt_state,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               rate
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIN_LOG2 < 1) begin : g_bad_cfg
        $error("lif_spike_monitor: DEPTH must be a power of 2 >= 2 and WIN_LOG2 >= 1");
    end

    logic [TS_W-1:0] ts_cnt;
    logic            spike_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            evt_edge;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    logic [TS_W-1:0] mem_ts    [DEPTH];
    logic [7:0]      mem_state [DEPTH];

    assign evt_edge  = en && spike && !spike_q;
    assign evt_valid = (fifo_count != '0);
    assign full      = (fifo_count == CW'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts the new event when the head leaves in the same cycle.
    assign push      = evt_edge && (!full || pop);
    assign drop      = evt_edge && full && !pop;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt     <= '0;
            spike_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (en) ts_cnt <= ts_cnt + 1'b1;
            spike_q <= spike;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nxt;
            if (drop)       overflow <= 1'b1;
            else if (clear) overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; emptiness comes from the pointers and count,
    // and the outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts[wr_ptr]    <= ts_cnt;
            mem_state[wr_ptr] <= state;
        end
    end

    assign evt_ts    = evt_valid ? mem_ts[rd_ptr]    : '0;
    assign evt_state = evt_valid ? mem_state[rd_ptr] : '0;

`ifdef SPIKE_RATE_EN
    logic [WIN_LOG2-1:0] win_cnt;
    logic [7:0]          spk_cnt;
    logic [7:0]          rate_q;
    logic                win_last;
    logic [8:0]          win_total;

    assign win_last  = en && (win_cnt == '1);
    // An edge on the window's final cycle is credited to the window that is ending.
    assign win_total = {1'b0, spk_cnt} + 9'(evt_edge);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt <= '0;
            spk_cnt <= '0;
            rate_q  <= '0;
        end else begin
            if (en) win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
                rate_q  <= win_total[8] ? 8'hFF : win_total[7:0];
                spk_cnt <= '0;
            end else if (evt_edge && spk_cnt != 8'hFF) begin
                spk_cnt <= spk_cnt + 1'b1;
            end
        end
    end

    assign rate = rate_q;
`else
    assign rate = 8'd0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: vector table for the basic capture path plus
// hand-written sequences for hold, overflow/clear, full push+pop, en=0, ts wrap, rate and reset.
module tb_lif_spike_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       spike;
    logic [7:0] state;
    logic       clear;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_ts;
    logic [7:0] evt_state;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] rate;

    int checks   = 0;
    int failures = 0;
    int tsm      = 0;

    lif_spike_monitor #(.TS_W(8), .DEPTH(4), .WIN_LOG2(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .spike      (spike),
        .state      (state),
        .clear      (clear),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ts     (evt_ts),
        .evt_state  (evt_state),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .rate       (rate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       spike;
        logic [7:0] state;
        logic       ready;
        logic       clear;
        logic       exp_valid;
        logic [7:0] exp_ts;
        logic [7:0] exp_state;
        int         exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input int ts, input logic [7:0] st,
                             input int cnt, input logic ovf);
        check({tag, ".valid"}, 32'(evt_valid), 32'(v));
        check({tag, ".ts"}, 32'(evt_ts), 32'(ts));
        check({tag, ".state"}, 32'(evt_state), 32'(st));
        check({tag, ".count"}, 32'(fifo_count), 32'(cnt));
        check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic step(input logic e, input logic sp, input logic [7:0] st,
                        input logic rdy, input logic clr);
        en = e; spike = sp; state = st; evt_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
        if (e) tsm = (tsm + 1) % 256;
    endtask

    initial begin
        int ev_ts[5];
        int t_new;
        int t_frz;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 0, 1'b0};
        vecs[1] = vecs[0];
        vecs[2] = vecs[0];
        vecs[3] = vecs[0];
        vecs[4] = vecs[0];
        vecs[5] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd5, 8'h3C, 1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd5, 8'h3C, 1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 0, 1'b0};

        reset_n = 1'b0; en = 0; spike = 0; state = 0; clear = 0; evt_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 0, 8'h00, 0, 1'b0);
        check("reset.rate", 32'(rate), 32'd0);
        reset_n = 1'b1;

        // Single-cycle spike at ts=5, stall, then pop.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].en, vecs[i].spike, vecs[i].state, vecs[i].ready, vecs[i].clear);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, int'(vecs[i].exp_ts),
                      vecs[i].exp_state, vecs[i].exp_count, vecs[i].exp_ovf);
        end

        // Spike held for 10 cycles is one event.
        t_new = tsm;
        step(1, 1, 8'h11, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 8'h22, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        check_out("hold", 1'b1, t_new, 8'h11, 1, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("hold_pop", 1'b0, 0, 8'h00, 0, 1'b0);

        // Five isolated events into a 4-deep FIFO with no consumer.
        for (int i = 0; i < 5; i++) begin
            ev_ts[i] = tsm;
            step(1, 1, 8'hA0 + 8'(i), 0, 0);
            step(1, 0, 8'h00, 0, 0);
            if (i == 3) check_out("fill4", 1'b1, ev_ts[0], 8'hA0, 4, 1'b0);
        end
        check_out("drop", 1'b1, ev_ts[0], 8'hA0, 4, 1'b1);
        step(1, 0, 8'h00, 0, 1);
        check_out("clear", 1'b1, ev_ts[0], 8'hA0, 4, 1'b0);

        // Full FIFO: push and pop in the same cycle, then drain to confirm order.
        t_new = tsm;
        step(1, 1, 8'h77, 1, 0);
        check_out("full_pp", 1'b1, ev_ts[1], 8'hA1, 4, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("drain1", 1'b1, ev_ts[2], 8'hA2, 3, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("drain2", 1'b1, ev_ts[3], 8'hA3, 2, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("drain3", 1'b1, t_new, 8'h77, 1, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("drain4", 1'b0, 0, 8'h00, 0, 1'b0);

        // en=0: spikes ignored, ts frozen, pops still work.
        t_new = tsm;
        step(1, 1, 8'h55, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        t_frz = tsm;
        step(0, 1, 8'h66, 0, 0);
        step(0, 0, 8'h66, 0, 0);
        step(0, 1, 8'h66, 0, 0);
        step(0, 0, 8'h66, 0, 0);
        check_out("en0_nopush", 1'b1, t_new, 8'h55, 1, 1'b0);
        step(0, 0, 8'h00, 1, 0);
        check_out("en0_pop", 1'b0, 0, 8'h00, 0, 1'b0);
        step(1, 1, 8'h99, 0, 0);
        check_out("ts_frozen", 1'b1, t_frz, 8'h99, 1, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("frz_pop", 1'b0, 0, 8'h00, 0, 1'b0);

        // Timestamp wrap: events at 254 and 0.
        while (tsm != 254) step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'hE1, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'hE2, 0, 0);
        check_out("wrap_a", 1'b1, 254, 8'hE1, 2, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("wrap_b", 1'b1, 0, 8'hE2, 1, 1'b0);
        step(1, 0, 8'h00, 1, 0);
        check_out("wrap_c", 1'b0, 0, 8'h00, 0, 1'b0);

        // Fresh reset to align the rate window.
        en = 0; spike = 0; evt_ready = 0; clear = 0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tsm = 0;

`ifdef SPIKE_RATE_EN
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) begin
                logic sp;
                sp = (w < 2) ? (i == 2 || i == 8 || i == 15) : (i == 15);
                step(1, sp, 8'h00, 1, 0);
                if (w == 0 && i == 14) check("rate_pre", 32'(rate), 32'd0);
                if (w == 1 && i == 14) check("rate_hold", 32'(rate), 32'd3);
            end
            check($sformatf("rate_w%0d", w), 32'(rate), (w < 2) ? 32'd3 : 32'd1);
        end
`else
        for (int i = 0; i < 20; i++) step(1, (i % 4) == 1, 8'h00, 1, 0);
        check("rate_tied", 32'(rate), 32'd0);
`endif

        // Asynchronous reset with an entry buffered.
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h42, 0, 0);
        check("pre_rst.valid", 32'(evt_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 0, 8'h00, 0, 1'b0);
        check("async_rst.rate", 32'(rate), 32'd0);
        #1;
        reset_n = 1'b1;
        step(1, 0, 8'h00, 0, 0);
        check_out("post_rst", 1'b0, 0, 8'h00, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
